// File: rtl/btn_debounce_tick.sv
// btn_debounce_tick: debounces a bank of raw push buttons against the 4 kHz
// enable pulse and produces a clean level plus one-cycle press/release pulses.
// Optional auto-repeat of press pulses while a button is held is compiled in
// when the macro BTN_AUTOREPEAT_EN is defined.
module btn_debounce_tick #(
  parameter int WIDTH        = 4,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 2000,
  parameter int REPEAT_RATE  = 400
) (
  input  logic             Pixelclock,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  // Reject parameter sets the counters cannot represent.
  if (STABLE_TICKS < 1 || STABLE_TICKS > 255 || REPEAT_RATE < 1 ||
      REPEAT_RATE > REPEAT_DELAY || REPEAT_DELAY > 65535) begin : g_badParams
    $error("btn_debounce_tick: illegal STABLE_TICKS/REPEAT_DELAY/REPEAT_RATE");
  end

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_press;
  logic [WIDTH-1:0] r_release;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_differ;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_repFire;

  // A button is accepted on the tick that completes its run of disagreeing ticks.
  always_comb begin
    w_differ = r_s2 ^ r_level;
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_differ[i] & tick & (r_cnt[i] == CNT_LAST);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [15:0] REP_FIRE   = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] REP_RELOAD = 16'(REPEAT_DELAY - REPEAT_RATE);

  logic [15:0] r_rep [WIDTH];

  // A held button fires a repeat on the tick that brings its counter to the
  // delay; a release-accept tick never fires so press and release stay exclusive.
  always_comb begin
    w_repFire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_repFire[i] = r_level[i] & tick & ~w_accept[i] & (r_rep[i] == REP_FIRE);
    end
  end

  // Repeat counter: idle while released, restarts on every accept, reloads
  // after each repeat so later pulses come every REPEAT_RATE ticks.
  always_ff @(posedge Pixelclock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) r_rep[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!r_level[i] || w_accept[i]) begin
          r_rep[i] <= '0;
        end else if (w_repFire[i]) begin
          r_rep[i] <= REP_RELOAD;
        end else if (tick) begin
          r_rep[i] <= r_rep[i] + 16'd1;
        end
      end
    end
  end
`else
  assign w_repFire = '0;
`endif

  // Synchronize raw inputs, count disagreeing ticks and register level/pulses.
  always_ff @(posedge Pixelclock) begin
    if (reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_s1      <= btn_raw;
      r_s2      <= r_s1;
      r_press   <= (w_accept & ~r_level) | w_repFire;
      r_release <= w_accept & r_level;
      r_level   <= r_level ^ w_accept;
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_differ[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else if (tick) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: tb/tb_btn_debounce_tick.sv
// Testbench for btn_debounce_tick: directed scenarios plus randomized button
// activity, checked cycle by cycle against a rule-level reference model.
module tb_btn_debounce_tick;

  localparam int W  = 4;
  localparam int ST = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b0;
  logic [W-1:0] btnRaw = '0;
  logic [W-1:0] btnLevel;
  logic [W-1:0] btnPress;
  logic [W-1:0] btnRelease;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tickPeriod = 10;

  // Reference model state: raw value seen two edges ago, accepted level,
  // ticks seen during the current disagreement, ticks held since press accept.
  logic [W-1:0] mDelay1 = '0;
  logic [W-1:0] mDelay2 = '0;
  logic [W-1:0] mLevel = '0;
  logic [W-1:0] mPress = '0;
  logic [W-1:0] mRelease = '0;
  int           mRun [W];
  int           mHeld [W];

  int pressCnt [W];
  int releaseCnt [W];

  btn_debounce_tick #(
    .WIDTH(W), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Pixelclock (clock),
    .reset      (reset),
    .tick       (tick),
    .btn_raw    (btnRaw),
    .btn_level  (btnLevel),
    .btn_press  (btnPress),
    .btn_release(btnRelease)
  );

  always #5 clock = ~clock;

  function automatic bit repeatDue(int held);
    if (held == RD) return 1'b1;
    if (held > RD && ((held - RD) % RR) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the reference model by one clock edge using the pre-edge inputs.
  task automatic modelEdge();
    logic [W-1:0] seen;
    logic [W-1:0] oldLevel;
    bit accepted;
    if (reset) begin
      mDelay1 = '0; mDelay2 = '0; mLevel = '0; mPress = '0; mRelease = '0;
      for (int i = 0; i < W; i++) begin mRun[i] = 0; mHeld[i] = 0; end
    end else begin
      seen = mDelay2;
      oldLevel = mLevel;
      mPress = '0;
      mRelease = '0;
      for (int i = 0; i < W; i++) begin
        accepted = 1'b0;
        if (seen[i] != oldLevel[i]) begin
          if (tick) begin
            mRun[i]++;
            if (mRun[i] == ST) begin
              accepted = 1'b1;
              mRun[i] = 0;
              mLevel[i] = ~oldLevel[i];
              if (oldLevel[i]) mRelease[i] = 1'b1;
              else begin mPress[i] = 1'b1; mHeld[i] = 0; end
            end
          end
        end else begin
          mRun[i] = 0;
        end
`ifdef BTN_AUTOREPEAT_EN
        if (oldLevel[i] && !accepted && tick) begin
          mHeld[i]++;
          if (repeatDue(mHeld[i])) mPress[i] = 1'b1;
        end
`endif
        if (!mLevel[i]) mHeld[i] = 0;
      end
      mDelay2 = mDelay1;
      mDelay1 = btnRaw;
    end
  endtask

  task automatic checkOutput(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkCount(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: set tick, take the edge, update the model, compare #1 later.
  task automatic applyStimulus();
    tick = ((cyc % tickPeriod) == tickPeriod - 1);
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput("level", btnLevel, mLevel);
    checkOutput("press", btnPress, mPress);
    checkOutput("release", btnRelease, mRelease);
    for (int i = 0; i < W; i++) begin
      pressCnt[i] += int'(btnPress[i]);
      releaseCnt[i] += int'(btnRelease[i]);
    end
    cyc++;
  endtask

  task automatic runCycles(int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic clearCounts();
    for (int i = 0; i < W; i++) begin pressCnt[i] = 0; releaseCnt[i] = 0; end
  endtask

  initial begin
    int simulPulses;
    int waited;
    int expRepeats;
    for (int i = 0; i < W; i++) begin mRun[i] = 0; mHeld[i] = 0; end
    clearCounts();

    // Reset with every button pressed
    btnRaw = 4'b1111;
    reset = 1'b1;
    runCycles(3);
    reset = 1'b0;
    applyStimulus();
    checkOutput("reset_level", btnLevel, 4'b0000);
    checkOutput("reset_press", btnPress, 4'b0000);
    btnRaw = 4'b0000;
    runCycles(60);

    // Clean press on button 0
    clearCounts();
    btnRaw = 4'b0001;
    runCycles(60);
    checkCount("clean_press_cnt", pressCnt[0], 1);
    checkCount("clean_release_cnt", releaseCnt[0], 0);
    checkOutput("clean_level", btnLevel, 4'b0001);

    // Bouncing button 1, random bounce period well under the acceptance window
    clearCounts();
    begin
      int period = int'($urandom_range(5, 25));
      for (int k = 0; k < 200; k++) begin
        if ((k % period) == 0) btnRaw[1] = ~btnRaw[1];
        applyStimulus();
      end
    end
    checkCount("bounce_no_press", pressCnt[1] + releaseCnt[1], 0);
    btnRaw[1] = 1'b1;
    runCycles(60);
    checkCount("bounce_press_cnt", pressCnt[1], 1);

    // Release button 0
    clearCounts();
    btnRaw[0] = 1'b0;
    runCycles(60);
    checkCount("release_cnt", releaseCnt[0], 1);

    // Press button 2, then release it and reset after two ticks
    btnRaw[2] = 1'b1;
    runCycles(60);
    clearCounts();
    btnRaw[2] = 1'b0;
    runCycles(2 + 2 * tickPeriod);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    runCycles(60);
    checkCount("reset_mid_no_release", releaseCnt[2], 0);
    checkOutput("reset_mid_level2", {3'b000, btnLevel[2]}, 4'b0000);

    // Simultaneous press of buttons 3 and 1
    btnRaw = 4'b0000;
    runCycles(80);
    clearCounts();
    simulPulses = 0;
    btnRaw = 4'b1010;
    for (int k = 0; k < 70; k++) begin
      applyStimulus();
      if (btnPress == 4'b1010) simulPulses++;
    end
    checkCount("simul_pulses", simulPulses, 1);
    checkCount("simul_other", pressCnt[0] + pressCnt[2], 0);

    // Hold button 3 and count press pulses over 18 ticks after accept
    btnRaw = 4'b0000;
    runCycles(80);
    clearCounts();
    btnRaw = 4'b1000;
    waited = 0;
    while (!btnLevel[3] && waited < 200) begin applyStimulus(); waited++; end
    checkCount("hold_accept_seen", int'(btnLevel[3]), 1);
    runCycles(18 * tickPeriod + 3);
`ifdef BTN_AUTOREPEAT_EN
    expRepeats = 5;
`else
    expRepeats = 1;
`endif
    checkCount("hold_press_cnt", pressCnt[3], expRepeats);
    btnRaw[3] = 1'b0;
    waited = 0;
    while (btnLevel[3] && waited < 200) begin applyStimulus(); waited++; end
    checkCount("hold_release_seen", int'(btnLevel[3]), 0);
    clearCounts();
    runCycles(100);
    checkCount("hold_no_press_after", pressCnt[3], 0);

    // Continuous tick with random slow input changes
    tickPeriod = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) btnRaw[$urandom_range(0, W - 1)] ^= 1'b1;
      applyStimulus();
    end

    // Random tick spacing, random bursts of bounce and occasional reset
    for (int blk = 0; blk < 12; blk++) begin
      tickPeriod = int'($urandom_range(1, 7));
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 9) == 0) btnRaw = W'($urandom);
        reset = ($urandom_range(0, 199) == 0);
        applyStimulus();
      end
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
